// File: rtl/noise_burst_ctrl.sv
// noise_burst_ctrl: gates the noise generator enable in programmable bursts.
// A sequence is max(burst_len,1) cycles on, gap_len cycles off, repeated
// rep_cnt times (0 = forever) until stop.
// Optional build macro NOISE_BURST_RAMP_EN adds a linear fade-in/out gain
// stage (noise_in -> noise_gated) driven by noise_en.
module noise_burst_ctrl #(
  parameter int unsigned CNT_W  = 24,
  parameter int unsigned REP_W  = 8,
  parameter int unsigned RAMP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic [CNT_W-1:0]  gap_len,
  input  logic [REP_W-1:0]  rep_cnt,
  output logic              noise_en,
  output logic              busy,
  output logic              done,
  output logic [REP_W-1:0]  burst_idx
`ifdef NOISE_BURST_RAMP_EN
  ,
  input  logic signed [15:0] noise_in,
  output logic signed [15:0] noise_gated
`endif
);

  typedef enum logic [1:0] {IDLE, BURST, GAP, FINISH} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [REP_W-1:0]   idx_d;
  logic [CNT_W-1:0]   blen_q, gap_q;
  logic [REP_W-1:0]   rep_q;
  logic               load_cfg;
  logic [CNT_W-1:0]   blen_m1;

  // Reload value for every burst after the first, from the latched length.
  assign blen_m1 = (blen_q == '0) ? '0 : blen_q - CNT_W'(1);

  // Next-state, counter and burst-index logic; stop has top priority.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    idx_d    = burst_idx;
    load_cfg = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_d  = BURST;
          cnt_d    = (burst_len == '0) ? '0 : burst_len - CNT_W'(1);
          idx_d    = '0;
          load_cfg = 1'b1;
        end
      end
      BURST: begin
        if (stop) begin
          state_d = IDLE;
        end else if (cnt != '0) begin
          cnt_d = cnt - CNT_W'(1);
        end else begin
          idx_d = burst_idx + REP_W'(1);
          if (rep_q != '0 && idx_d == rep_q) begin
            state_d = FINISH;
          end else if (gap_q == '0) begin
            cnt_d = blen_m1;
          end else begin
            state_d = GAP;
            cnt_d   = gap_q - CNT_W'(1);
          end
        end
      end
      GAP: begin
        if (stop) begin
          state_d = IDLE;
        end else if (cnt != '0) begin
          cnt_d = cnt - CNT_W'(1);
        end else begin
          state_d = BURST;
          cnt_d   = blen_m1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and registered outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      burst_idx <= '0;
      noise_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      burst_idx <= idx_d;
      noise_en  <= (state_d == BURST);
      busy      <= (state_d != IDLE);
      done      <= (state_d == FINISH);
    end
  end

  // Configuration snapshot taken only when a sequence is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blen_q <= '0;
      gap_q  <= '0;
      rep_q  <= '0;
    end else if (load_cfg) begin
      blen_q <= burst_len;
      gap_q  <= gap_len;
      rep_q  <= rep_cnt;
    end
  end

`ifdef NOISE_BURST_RAMP_EN
  localparam int unsigned PROD_W = 16 + RAMP_W + 2;
  localparam logic [RAMP_W:0] G_MAX = {1'b1, {RAMP_W{1'b0}}};

  logic [RAMP_W:0]          gain;
  logic signed [PROD_W-1:0] prod;

  assign prod = PROD_W'(noise_in) * PROD_W'($signed({1'b0, gain}));

  // Gain ramps toward full scale while enabled and toward zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gain <= '0;
    end else if (noise_en && gain < G_MAX) begin
      gain <= gain + (RAMP_W+1)'(1);
    end else if (!noise_en && gain != '0) begin
      gain <= gain - (RAMP_W+1)'(1);
    end
  end

  // Scaled sample; full gain is an exact one-cycle pass-through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      noise_gated <= '0;
    end else begin
      noise_gated <= 16'(prod >>> RAMP_W);
    end
  end
`endif

endmodule

// File: tb/tb_noise_burst_ctrl.sv
// Scoreboard bench for noise_burst_ctrl: stimulus queues per-cycle expected
// outputs, a negedge monitor pops and compares them.
module tb_noise_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [23:0] burst_len = '0;
  logic [23:0] gap_len = '0;
  logic [7:0]  rep_cnt = '0;
  logic        noise_en;
  logic        busy;
  logic        done;
  logic [7:0]  burst_idx;
`ifdef NOISE_BURST_RAMP_EN
  logic signed [15:0] noise_in = 16'sh4000;
  logic signed [15:0] noise_gated;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int base = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic        ne;
    logic        bz;
    logic        dn;
    logic [7:0]  idx;
  } exp_t;

  exp_t sb_q[$];

  noise_burst_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .burst_len (burst_len),
    .gap_len   (gap_len),
    .rep_cnt   (rep_cnt),
    .noise_en  (noise_en),
    .busy      (busy),
    .done      (done),
    .burst_idx (burst_idx)
`ifdef NOISE_BURST_RAMP_EN
    ,
    .noise_in    (noise_in),
    .noise_gated (noise_gated)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare each queued expectation on its own cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && int'(sb_q[0].cyc) < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_slot cyc=%0d expected entry never sampled", sb_q[0].cyc);
      void'(sb_q.pop_front());
    end
    if (sb_q.size() > 0 && int'(sb_q[0].cyc) == cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      if ({noise_en, busy, done, burst_idx} !== {e.ne, e.bz, e.dn, e.idx}) begin
        errors++;
        $display("FAIL seq_k%0d got ne=%b busy=%b done=%b idx=%0d want ne=%b busy=%b done=%b idx=%0d",
                 cyc - base, noise_en, busy, done, burst_idx, e.ne, e.bz, e.dn, e.idx);
      end
    end
  end

  task automatic push(input int k, input logic ne, input logic bz, input logic dn,
                      input logic [7:0] idx);
    exp_t e;
    e.cyc = 32'(base + k);
    e.ne  = ne;
    e.bz  = bz;
    e.dn  = dn;
    e.idx = idx;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp_v);
    end
  endtask

  task automatic wait_to(input int k);
    while (cyc < base + k) @(negedge clk);
  endtask

  task automatic go(input logic [23:0] bl, input logic [23:0] gl, input logic [7:0] rc);
    @(negedge clk);
    burst_len = bl;
    gap_len   = gl;
    rep_cnt   = rc;
    start     = 1'b1;
    base      = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_state", 32'({noise_en, busy, done, burst_idx}), 32'h0);
    rst = 1'b0;

    // 5 on, 3 off, 2 bursts
    go(24'd5, 24'd3, 8'd2);
    for (int k = 1; k <= 15; k++)
      push(k, (k <= 5) || (k >= 9 && k <= 13), k <= 14, k == 14,
           (k <= 5) ? 8'd0 : ((k <= 13) ? 8'd1 : 8'd2));
    wait_to(1); start = 1'b0;
    wait_to(16);

    // Zero lengths: 3 back-to-back single-cycle bursts
    go(24'd0, 24'd0, 8'd3);
    for (int k = 1; k <= 5; k++)
      push(k, k <= 3, k <= 4, k == 4, (k <= 3) ? 8'(k - 1) : 8'd3);
    wait_to(1); start = 1'b0;
    wait_to(6);

    // Infinite mode, 2 on / 2 off, stopped during the gap after 10 bursts
    go(24'd2, 24'd2, 8'd0);
    for (int k = 1; k <= 42; k++) begin
      if (k <= 40) push(k, ((k - 1) % 4) < 2, 1'b1, 1'b0, 8'((k + 1) / 4));
      else         push(k, 1'b0, 1'b0, 1'b0, 8'd10);
    end
    wait_to(1); start = 1'b0;
    wait_to(40); stop = 1'b1;
    wait_to(41); stop = 1'b0;
    wait_to(43);

    // start and stop together in IDLE: nothing happens, idx holds
    @(negedge clk);
    start = 1'b1; stop = 1'b1; base = cyc;
    for (int k = 1; k <= 3; k++) push(k, 1'b0, 1'b0, 1'b0, 8'd10);
    wait_to(1); start = 1'b0; stop = 1'b0;
    wait_to(4);

    // Config change and start while busy are ignored
    go(24'd4, 24'd1, 8'd2);
    for (int k = 1; k <= 11; k++)
      push(k, (k <= 4) || (k >= 6 && k <= 9), k <= 10, k == 10,
           (k <= 4) ? 8'd0 : ((k <= 9) ? 8'd1 : 8'd2));
    wait_to(1); start = 1'b0;
    wait_to(2);
    burst_len = 24'd9; gap_len = 24'd7; rep_cnt = 8'd5; start = 1'b1;
    wait_to(3); start = 1'b0;
    wait_to(12);

    // Asynchronous reset in the middle of a burst
    go(24'd8, 24'd0, 8'd0);
    for (int k = 1; k <= 3; k++) push(k, 1'b1, 1'b1, 1'b0, 8'd0);
    for (int k = 4; k <= 6; k++) push(k, 1'b0, 1'b0, 1'b0, 8'd0);
    wait_to(1); start = 1'b0;
    wait_to(3);
    #2 rst = 1'b1;
    #1 chk("async_rst", 32'({noise_en, busy, done, burst_idx}), 32'h0);
    wait_to(4); rst = 1'b0;
    wait_to(7);

`ifdef NOISE_BURST_RAMP_EN
    // Fade-in over 16 cycles, hold, fade-out over 16 cycles after the burst
    go(24'd32, 24'd0, 8'd1);
    wait_to(1); start = 1'b0;
    for (int k = 2; k <= 52; k++) begin
      int g;
      int t;
      wait_to(k);
      t = k - 1;
      if (t <= 1)       g = 0;
      else if (t <= 17) g = t - 1;
      else if (t <= 33) g = 16;
      else if (t <= 49) g = 16 - (t - 33);
      else              g = 0;
      chk("ramp_gated", 32'(noise_gated), 32'(g * 32'h400));
    end
`endif

    repeat (4) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain left=%0d want=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
